// File: rtl/delay_timer_gen2.sv
// -----------------------------------------------------------------------------
// delay_timer_gen2
//
// Trigger-started programmable delay timer. A start loads a down-counter with
// max(n,1)-1. When the counter reaches zero, time_out is raised for PULSE_W
// cycles. Afterwards the timer either reloads (periodic mode) or waits for
// trigger to drop (one-shot mode). A synchronous abort cancels any activity.
//
// Parameters:
//   BIT_SZ   width of the delay value n and of the remaining-count status
//   PULSE_W  number of cycles time_out stays high per expiry (1..255)
//
// Ports:
//   sysclk     in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   trigger    in   start request, level-sampled
//   n          in   delay length in cycles (0 behaves as 1)
//   periodic   in   1 = auto-reload, 0 = one-shot (sampled at start)
//   abort      in   synchronous cancel, highest priority
//   time_out   out  expiry pulse
//   busy       out  high while counting or pulsing
//   remaining  out  current count while counting, 0 otherwise
//
// Compile-time option:
//   DELAY_RETRIG_EN  when defined, a rising edge of trigger while counting or
//                    pulsing restarts the delay with a freshly sampled n.
// -----------------------------------------------------------------------------
module delay_timer_gen2 #(
    parameter int BIT_SZ  = 10,
    parameter int PULSE_W = 1
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic              trigger,
    input  logic [BIT_SZ-1:0] n,
    input  logic              periodic,
    input  logic              abort,
    output logic              time_out,
    output logic              busy,
    output logic [BIT_SZ-1:0] remaining
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        COUNTING = 2'b01,
        TIME_OUT = 2'b10,
        WAIT_LOW = 2'b11
    } state_t;

    localparam logic [BIT_SZ-1:0] ONE        = {{(BIT_SZ-1){1'b0}}, 1'b1};
    localparam logic [7:0]        PULSE_LAST = 8'(PULSE_W - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [BIT_SZ-1:0] r_count;
    logic [BIT_SZ-1:0] r_n_lat;
    logic              r_per_lat;
    logic [7:0]        r_pulse_cnt;
    logic              r_time_out;
    logic              r_busy;

    logic [BIT_SZ-1:0] w_n_eff;
    logic              w_count_zero;
    logic              w_pulse_last;
    logic              w_retrig;
    logic              w_time_out_nxt;
    logic              w_busy_nxt;

    // A programmed delay of 0 is treated as 1 so the counter never underflows.
    assign w_n_eff      = (n == '0) ? ONE : n;
    assign w_count_zero = (r_count == '0);
    assign w_pulse_last = (r_pulse_cnt == PULSE_LAST);

`ifdef DELAY_RETRIG_EN
    logic r_trig_d;

    // Reset to 1 so a trigger already high when reset releases is not an edge.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) r_trig_d <= 1'b1;
        else        r_trig_d <= trigger;
    end

    assign w_retrig = trigger && !r_trig_d &&
                      ((r_state == COUNTING) || (r_state == TIME_OUT));
`else
    assign w_retrig = 1'b0;
`endif

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic. Abort outranks retrigger, which outranks normal flow.
    // NOTE: the default assignment first keeps this combinational block free
    // of inferred latches on paths that do not change state.
    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = WAIT_LOW;
        end else if (w_retrig) begin
            w_state_nxt = COUNTING;
        end else begin
            case (r_state)
                IDLE:     if (trigger)      w_state_nxt = COUNTING;
                COUNTING: if (w_count_zero) w_state_nxt = TIME_OUT;
                TIME_OUT: if (w_pulse_last) w_state_nxt = r_per_lat ? COUNTING : WAIT_LOW;
                WAIT_LOW: if (!trigger)     w_state_nxt = IDLE;
                default:                    w_state_nxt = IDLE;
            endcase
        end
    end

    // Output decode: outputs are registered copies of the upcoming state, so
    // time_out rises on the same edge that enters TIME_OUT.
    always_comb begin
        w_time_out_nxt = (w_state_nxt == TIME_OUT);
        w_busy_nxt     = (w_state_nxt == COUNTING) || (w_state_nxt == TIME_OUT);
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_time_out <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_time_out <= w_time_out_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    // Datapath: latched configuration, delay counter and pulse-width counter.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_n_lat     <= '0;
            r_per_lat   <= 1'b0;
            r_pulse_cnt <= '0;
        end else if (abort) begin
            r_count     <= '0;
            r_pulse_cnt <= '0;
        end else if (w_retrig) begin
            r_n_lat     <= w_n_eff;
            r_count     <= w_n_eff - ONE;
            r_pulse_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (trigger) begin
                        r_n_lat   <= w_n_eff;
                        r_per_lat <= periodic;
                        r_count   <= w_n_eff - ONE;
                    end
                end
                COUNTING: begin
                    if (w_count_zero) r_pulse_cnt <= '0;
                    else              r_count     <= r_count - ONE;
                end
                TIME_OUT: begin
                    if (w_pulse_last) begin
                        r_pulse_cnt <= '0;
                        if (r_per_lat) r_count <= r_n_lat - ONE;
                    end else begin
                        r_pulse_cnt <= r_pulse_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign time_out  = r_time_out;
    assign busy      = r_busy;
    assign remaining = (r_state == COUNTING) ? r_count : '0;

endmodule
